// File: rtl/map_scroll_arbiter_if.sv
// Requester-side handshake bundle for the map ROM arbiter: renderer (r_*) and game logic (g_*).
// master = requester side, slave = arbiter side.
interface map_scroll_arbiter_if #(
  parameter int unsigned ROW_W = 7
);
  logic             r_req;
  logic [2:0]       r_lane;
  logic [ROW_W-1:0] r_row;
  logic             r_gnt;
  logic             r_valid;
  logic [2:0]       r_state;

  logic             g_req;
  logic [2:0]       g_lane;
  logic [ROW_W-1:0] g_row;
  logic             g_gnt;
  logic             g_valid;
  logic [2:0]       g_state;

  modport master (
    output r_req, r_lane, r_row,
    input  r_gnt, r_valid, r_state,
    output g_req, g_lane, g_row,
    input  g_gnt, g_valid, g_state
  );

  modport slave (
    input  r_req, r_lane, r_row,
    output r_gnt, r_valid, r_state,
    input  g_req, g_lane, g_row,
    output g_gnt, g_valid, g_state
  );
endinterface

// File: rtl/map_scroll_arbiter.sv
// Shares the single registered-read tile map ROM port between renderer and game logic,
// and owns the level scroll position with its IDLE/RUN/DONE sequence.
module map_scroll_arbiter #(
  parameter int unsigned LANES = 5,
  parameter int unsigned ROW_W = 7,
  parameter int unsigned LEN_W = 11,
  parameter int unsigned LOOP  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             tick,
  input  logic [LEN_W-1:0] map_len,
  map_scroll_arbiter_if.slave bus,
  output logic [2:0]       map_x,
  output logic [ROW_W-1:0] map_y,
  input  logic [2:0]       map_state,
  output logic [ROW_W-1:0] scroll_pos,
  output logic             wrap,
  output logic             done
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [ROW_W-1:0] pos_q, pos_d;
  logic             wrap_q, wrap_d;
  logic [LEN_W-1:0] pos_ext, last_row;

  assign pos_ext  = LEN_W'(pos_q);
  assign last_row = map_len - LEN_W'(1);

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    wrap_d  = 1'b0;
    if (start) begin
      state_d = StRun;
      pos_d   = '0;
    end else if (state_q == StRun && tick) begin
      // A position left beyond a shrunken map snaps back to the top.
      if (pos_ext >= map_len) begin
        pos_d = '0;
      end else if (pos_ext == last_row) begin
        if (LOOP != 0) begin
          pos_d  = '0;
          wrap_d = 1'b1;
        end else begin
          state_d = StDone;
        end
      end else begin
        pos_d = pos_q + ROW_W'(1);
      end
    end
  end

  // Arbitration: prefer_g_q names who wins the next contested cycle.
  logic prefer_g_q, prefer_g_d;
  logic r_gnt_w, g_gnt_w, any_gnt;

  assign g_gnt_w    = bus.g_req & (~bus.r_req | prefer_g_q);
  assign r_gnt_w    = bus.r_req & ~g_gnt_w;
  assign any_gnt    = r_gnt_w | g_gnt_w;
  assign prefer_g_d = (bus.r_req & bus.g_req) ? ~g_gnt_w : prefer_g_q;

  assign bus.r_gnt = r_gnt_w;
  assign bus.g_gnt = g_gnt_w;

  // Address: relative row plus scroll position, folded once at map_len.
  logic [2:0]       sel_lane;
  logic [ROW_W-1:0] sel_row;
  logic [ROW_W:0]   sum;
  logic [LEN_W-1:0] sum_ext, sum_fold;
  logic             lane_oor;
  logic [2:0]       map_x_q;
  logic [ROW_W-1:0] map_y_q;

  assign sel_lane = g_gnt_w ? bus.g_lane : bus.r_lane;
  assign sel_row  = g_gnt_w ? bus.g_row : bus.r_row;
  assign sum      = {1'b0, pos_q} + {1'b0, sel_row};
  assign sum_ext  = LEN_W'(sum);
  assign sum_fold = (sum_ext >= map_len) ? (sum_ext - map_len) : sum_ext;
  assign lane_oor = 32'(sel_lane) >= LANES;

  always_comb begin
    map_x = map_x_q;
    map_y = map_y_q;
    if (any_gnt) begin
      map_x = lane_oor ? 3'd0 : sel_lane;
      map_y = ROW_W'(sum_fold);
    end
  end

  // Response: ROM data arrives the cycle after the grant and is held until the next read.
  logic       r_pend_q, g_pend_q, r_oor_q, g_oor_q;
  logic [2:0] r_state_q, g_state_q, r_state_w, g_state_w;

  always_comb begin
    r_state_w = r_state_q;
    g_state_w = g_state_q;
    if (r_pend_q) r_state_w = r_oor_q ? 3'd0 : map_state;
    if (g_pend_q) g_state_w = g_oor_q ? 3'd0 : map_state;
  end

  assign bus.r_valid = r_pend_q;
  assign bus.g_valid = g_pend_q;
  assign bus.r_state = r_state_w;
  assign bus.g_state = g_state_w;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      pos_q      <= '0;
      wrap_q     <= 1'b0;
      prefer_g_q <= 1'b1;
      map_x_q    <= '0;
      map_y_q    <= '0;
      r_pend_q   <= 1'b0;
      g_pend_q   <= 1'b0;
      r_oor_q    <= 1'b0;
      g_oor_q    <= 1'b0;
      r_state_q  <= '0;
      g_state_q  <= '0;
    end else begin
      state_q    <= state_d;
      pos_q      <= pos_d;
      wrap_q     <= wrap_d;
      prefer_g_q <= prefer_g_d;
      map_x_q    <= map_x;
      map_y_q    <= map_y;
      r_pend_q   <= r_gnt_w;
      g_pend_q   <= g_gnt_w;
      r_oor_q    <= r_gnt_w & lane_oor;
      g_oor_q    <= g_gnt_w & lane_oor;
      r_state_q  <= r_state_w;
      g_state_q  <= g_state_w;
    end
  end

  assign scroll_pos = pos_q;
  assign wrap       = wrap_q;
  assign done       = (state_q == StDone);

endmodule
